run_detect_ctrl: RTL and testbench
==================================

Name: run_detect_ctrl

Overview:
- Controller that sequences a serial run-of-ones detection job over a bounded window of input bits.
- Software or an upstream FSM issues `start` with a run length and a window size. The block consumes exactly that many valid bits, raises a Moore `detect` flag while the current run meets the length, counts distinct qualifying runs, then signals `done`.
- Sits between the configuration/control logic and the serial data source.

Parameters:
- LEN_W, 4, width of the run-length configuration and of the internal run counter.
- WIN_W, 8, width of the window-size configuration and of the bit counter.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- cfg_len  input  LEN_W  required run length (1..2^LEN_W-1); latched on accepted start.
- cfg_win  input  WIN_W  number of valid bits to consume (1..2^WIN_W-1); latched on accepted start.
- data_valid  input  1  `data_in` carries a bit this cycle.
- data_in  input  1  serial data bit.
- busy  output  1  high in RUN and DONE.
- detect  output  1  registered; high while the current run is >= the latched length.
- det_count  output  CNT_W  number of distinct runs that reached the length; saturating.
- done  output  1  one-cycle pulse at job end.
- err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; busy, detect, done and err = 0; det_count=0; run, bit and latched-config registers = 0. A reset asserted mid-job aborts the job with no done pulse.
- Fixed decision: one clock; synchronous active-high reset; ports named `clk` and `reset`.
- State machine is Moore, binary-encoded: IDLE=2'b00, RUN=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and returns to IDLE next edge with outputs 0.
- IDLE:
  - start=1 with cfg_len==0 or cfg_win==0: err=1 for the next cycle only; stay IDLE; det_count unchanged.
  - start=1 with valid config: latch cfg_len/cfg_win; clear run counter, bit counter and det_count; detect=0; go to RUN.
  - data_valid is ignored in IDLE.
- RUN, on each edge with data_valid=1:
  - run_next = data_in ? min(run+1, 2^LEN_W-1) : 0.
  - detect <= (run_next >= len_q).
  - det_count increments, saturating at 2^CNT_W-1, when detect goes 0->1, i.e. exactly once per qualifying run, including when the run counter is saturated.
  - bit counter increments. When the consumed bit is number win_q, go to DONE on that same edge.
- RUN, on edges with data_valid=0: all registers hold; no timeout.
- DONE:
  - done=1 for this single cycle.
  - detect and det_count hold the final values.
  - Next edge: go to IDLE and clear detect. det_count holds until the next accepted start.
- Latency: bit consumed at edge k, so detect and det_count reflect it after edge k. done is high the cycle after the last bit's edge.
- start during RUN or DONE is ignored.
- cfg_len/cfg_win changes after latching have no effect.
- busy = (state != IDLE), decoded from the state register only.

Decomposition:
- Shared package `run_detect_pkg`:
  - state localparams S_IDLE, S_RUN, S_DONE (2-bit);
  - default widths LEN_W/WIN_W/CNT_W.
- One natural sub-module, `run_len_cnt`:
  - saturating run-length counter plus >= comparator;
  - inputs: clk, reset, clr, en (= RUN and data_valid), bit, len_q;
  - outputs: run_next compare result and the registered detect.
- Top level holds the FSM, bit counter, config latches, det_count and the done/err pulses.

Test Plan:
1. cfg_len=3, cfg_win=8, bits 1,1,1,1,0,1,1,1 all valid, back-to-back -> detect high after bits 3, 4 and 8; det_count=2; done pulse one cycle after bit 8; busy low the cycle after that.
2. Same job with data_valid low for 2 cycles between every bit -> identical detect pattern (per valid bit) and det_count=2; done delayed by the idle cycles.
3. start with cfg_len=0 (and separately cfg_win=0) -> err=1 for exactly one cycle; busy stays 0; det_count unchanged.
4. start pulses and cfg changes (cfg_len=1) during RUN -> ignored; result matches the originally latched cfg_len=3.
5. cfg_len=15, cfg_win=20, 20 consecutive ones -> run saturates at 15, detect high from bit 15 on, det_count=1. Separately, assert reset at bit 10 -> all outputs 0 after that edge, no done pulse, FSM in IDLE.
6. CNT_W=2, cfg_len=1, cfg_win=10, pattern 1,0 repeated -> 5 qualifying runs; det_count saturates at 3; done asserted once.

Source files
------------

// File: rtl/run_detect_pkg.sv
// -----------------------------------------------------------------------------
// run_detect_pkg
// Shared definitions for the run-of-ones detection controller.
//   - state_t  : binary-encoded FSM states (2'b11 is an illegal encoding)
//   - DEF_*_W  : default widths for run length, window size and detection count
// -----------------------------------------------------------------------------
package run_detect_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DONE    = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam int DEF_LEN_W = 4;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/run_len_cnt.sv
// -----------------------------------------------------------------------------
// run_len_cnt
// Saturating run-of-ones counter with a >= comparator against the latched
// required length.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_clr       : clear run counter and detect (job start / job end)
//   i_en        : a bit is consumed this cycle
//   i_bit       : the consumed data bit
//   i_len_q     : latched required run length
//   o_hit       : combinational (run_next >= i_len_q)
//   o_detect    : registered detect flag
// -----------------------------------------------------------------------------
module run_len_cnt
  import run_detect_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  input  logic [LEN_W-1:0] i_len_q,
  output logic             o_hit,
  output logic             o_detect
);

  localparam logic [LEN_W-1:0] RUN_MAX = '1;

  logic [LEN_W-1:0] r_run;
  logic [LEN_W-1:0] w_run_next;
  logic             r_detect;

  // The counter sticks at its maximum so a very long run keeps comparing
  // true instead of wrapping back below the length.
  always_comb begin
    w_run_next = '0;
    if (i_bit) begin
      if (r_run == RUN_MAX) w_run_next = RUN_MAX;
      else                  w_run_next = r_run + 1'b1;
    end
  end

  assign o_hit = (w_run_next >= i_len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run    <= '0;
      r_detect <= 1'b0;
    end else if (i_clr) begin
      r_run    <= '0;
      r_detect <= 1'b0;
    end else if (i_en) begin
      r_run    <= w_run_next;
      r_detect <= o_hit;
    end
  end

  assign o_detect = r_detect;

endmodule

// File: rtl/run_detect_ctrl.sv
// -----------------------------------------------------------------------------
// run_detect_ctrl
// Sequences a run-of-ones detection job over a window of valid serial bits.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : job request (sampled in IDLE only)
//   cfg_len      : required run length, latched on an accepted start
//   cfg_win      : number of valid bits to consume, latched on an accepted start
//   data_valid   : data_in carries a bit this cycle
//   data_in      : serial data bit
//   busy         : high in RUN and DONE
//   detect       : registered, high while current run >= latched length
//   det_count    : saturating count of distinct qualifying runs
//   done         : one-cycle pulse at job end
//   err          : one-cycle pulse on a rejected start (zero length or window)
// -----------------------------------------------------------------------------
module run_detect_ctrl
  import run_detect_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             busy,
  output logic             detect,
  output logic [CNT_W-1:0] det_count,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [LEN_W-1:0] r_len_q;
  logic [WIN_W-1:0] r_win_q;
  logic [WIN_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_det_count;
  logic             r_done;
  logic             r_err;

  logic             w_cfg_ok;
  logic             w_accept;
  logic             w_consume;
  logic [WIN_W-1:0] w_bit_cnt_inc;
  logic             w_last;
  logic             w_clr;
  logic             w_hit;
  logic             w_detect;
  logic             w_rise;

  assign w_cfg_ok      = (cfg_len != '0) && (cfg_win != '0);
  assign w_accept      = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_consume     = (r_state == S_RUN) && data_valid;
  assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
  assign w_last        = (w_bit_cnt_inc == r_win_q);

  // Detect is cleared on a new job, when leaving DONE, and on recovery from
  // the illegal encoding.
  assign w_clr = w_accept || (r_state == S_DONE) || (r_state == S_ILLEGAL);

  // A qualifying run is counted on its 0->1 detect edge only, so a saturated
  // run counter that keeps hitting does not count again.
  assign w_rise = w_consume && w_hit && !w_detect;

  run_len_cnt #(
    .LEN_W (LEN_W)
  ) u_run_len_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_consume),
    .i_bit    (data_in),
    .i_len_q  (r_len_q),
    .o_hit    (w_hit),
    .o_detect (w_detect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len_q     <= '0;
      r_win_q     <= '0;
      r_bit_cnt   <= '0;
      r_det_count <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_cfg_ok) begin
              r_err <= 1'b1;
            end else begin
              r_len_q     <= cfg_len;
              r_win_q     <= cfg_win;
              r_bit_cnt   <= '0;
              r_det_count <= '0;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (data_valid) begin
            r_bit_cnt <= w_bit_cnt_inc;
            if (w_rise && (r_det_count != CNT_MAX))
              r_det_count <= r_det_count + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_det_count <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign detect    = w_detect;
  assign det_count = r_det_count;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_run_detect_ctrl.sv
module tb_run_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cfg_len;
  logic [7:0] cfg_win;
  logic       data_valid;
  logic       data_in;

  logic       busy, detect, done, err;
  logic [7:0] det_count;
  logic       busy2, detect2, done2, err2;
  logic [1:0] det_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_detect_ctrl #(.LEN_W(4), .WIN_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_win(cfg_win),
    .data_valid(data_valid), .data_in(data_in), .busy(busy), .detect(detect),
    .det_count(det_count), .done(done), .err(err)
  );

  // Narrow-count instance sharing the same stimulus, for the saturation case.
  run_detect_ctrl #(.LEN_W(4), .WIN_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_win(cfg_win),
    .data_valid(data_valid), .data_in(data_in), .busy(busy2), .detect(detect2),
    .det_count(det_count2), .done(done2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Runs one job: bits[i] is the i-th bit, expdet[i] the detect value after it.
  task automatic run_job(input string tag, input int len, input int win,
                         input logic [31:0] bits, input logic [31:0] expdet,
                         input int gap, input int expcnt, input bit disturb);
    start = 1'b1; cfg_len = 4'(len); cfg_win = 8'(win); data_valid = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 1);
    chk({tag, "_cnt_start"}, 32'(det_count), 0);
    for (int i = 0; i < win; i++) begin
      if (disturb && i == 2) begin
        start = 1'b1; cfg_len = 4'd1; cfg_win = 8'd3;
      end
      data_valid = 1'b1;
      data_in    = bits[i];
      tick();
      start = 1'b0;
      data_valid = 1'b0;
      data_in = 1'b0;
      chk($sformatf("%s_det_bit%0d", tag, i + 1), 32'(detect), 32'(expdet[i]));
      chk($sformatf("%s_done_bit%0d", tag, i + 1), 32'(done), (i == win - 1) ? 1 : 0);
      if (i < win - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk($sformatf("%s_hold_bit%0d", tag, i + 1), 32'(detect), 32'(expdet[i]));
          chk($sformatf("%s_busy_gap%0d", tag, i + 1), 32'(busy), 1);
        end
      end
    end
    chk({tag, "_cnt_final"}, 32'(det_count), 32'(expcnt));
    chk({tag, "_busy_done"}, 32'(busy), 1);
    tick();
    chk({tag, "_done_after"}, 32'(done), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_det_after"}, 32'(detect), 0);
    chk({tag, "_cnt_after"}, 32'(det_count), 32'(expcnt));
    cfg_len = 4'd0; cfg_win = 8'd0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_win = '0;
    data_valid = 1'b0; data_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_detect", 32'(detect), 0);
    chk("rst_cnt", 32'(det_count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    tick();

    // 1: bits 1,1,1,1,0,1,1,1 (bit0 first); detect after bits 3,4,8.
    run_job("t1", 3, 8, 32'b1110_1111, 32'b1000_1100, 0, 2, 1'b0);
    $display("t1 back-to-back job complete, det_count=%0d", det_count);

    // 2: same job with two idle cycles between valid bits.
    run_job("t2", 3, 8, 32'b1110_1111, 32'b1000_1100, 2, 2, 1'b0);
    $display("t2 gapped job complete, det_count=%0d", det_count);

    // 3: rejected starts.
    start = 1'b1; cfg_len = 4'd0; cfg_win = 8'd8;
    tick();
    start = 1'b0;
    chk("t3a_err", 32'(err), 1);
    chk("t3a_busy", 32'(busy), 0);
    chk("t3a_cnt", 32'(det_count), 2);
    tick();
    chk("t3a_err_clr", 32'(err), 0);
    start = 1'b1; cfg_len = 4'd3; cfg_win = 8'd0;
    tick();
    start = 1'b0;
    chk("t3b_err", 32'(err), 1);
    chk("t3b_busy", 32'(busy), 0);
    chk("t3b_cnt", 32'(det_count), 2);
    tick();
    chk("t3b_err_clr", 32'(err), 0);
    chk("t3b_busy2", 32'(busy), 0);
    $display("t3 rejected starts complete, det_count=%0d", det_count);

    // 4: start and cfg changes mid-run are ignored.
    run_job("t4", 3, 8, 32'b1110_1111, 32'b1000_1100, 0, 2, 1'b1);
    $display("t4 disturbed job complete, det_count=%0d", det_count);

    // 5: 20 ones with length 15; run saturates, one qualifying run.
    run_job("t5", 15, 20, 32'h000F_FFFF, 32'h000F_C000, 0, 1, 1'b0);
    $display("t5 saturation job complete, det_count=%0d", det_count);

    // 5b: reset asserted together with bit 10 aborts the job.
    start = 1'b1; cfg_len = 4'd15; cfg_win = 8'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      data_valid = 1'b1; data_in = 1'b1;
      tick();
    end
    chk("t5b_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; data_valid = 1'b0; data_in = 1'b0;
    chk("t5b_busy", 32'(busy), 0);
    chk("t5b_detect", 32'(detect), 0);
    chk("t5b_cnt", 32'(det_count), 0);
    chk("t5b_done", 32'(done), 0);
    chk("t5b_err", 32'(err), 0);
    for (int i = 0; i < 12; i++) begin
      data_valid = 1'b1; data_in = 1'b1;
      tick();
      chk($sformatf("t5b_nodone%0d", i), 32'(done), 0);
      chk($sformatf("t5b_idle%0d", i), 32'(busy), 0);
    end
    data_valid = 1'b0; data_in = 1'b0;
    $display("t5b reset abort complete");

    // 6: pattern 1,0 x5 with length 1: five runs, narrow counter saturates at 3.
    run_job("t6", 1, 10, 32'b01_0101_0101, 32'b01_0101_0101, 0, 5, 1'b0);
    chk("t6_cnt2_sat", 32'(det_count2), 3);
    chk("t6_busy2", 32'(busy2), 0);
    chk("t6_done2", 32'(done2), 0);
    $display("t6 saturating count complete, det_count=%0d det_count2=%0d", det_count, det_count2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
